// File: rtl/pc_sequencer.sv
// Next-PC controller: selects the fetch address and generates the stall, flush and exception-entry signals.
// Optional misaligned-target check (jr/eret sources) is enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h00003000,
    parameter logic [31:0] EXC_VEC  = 32'h00004180,
    parameter int          MULT_LAT = 5,
    parameter int          DIV_LAT  = 10,
    parameter int          CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        j_en,
    input  logic [31:0] j_target,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
    input  logic        eret_en,
    input  logic [31:0] epc_in,
    input  logic        int_req,
    input  logic        hz_stall,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        md_use,
    output logic [31:0] pc_next,
    output logic        pc_nen,
    output logic        flush,
    output logic        md_busy,
    output logic [31:0] epc_out,
    output logic        exc_ack
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic        adel
`endif
);

    typedef enum logic {
        RUN = 1'b0,
        EXC = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_epc;
    logic [31:0]      w_pc_sel;
    logic             w_reg_src;
    logic             w_stall;
    logic             w_take_int;
    logic             w_misalign;

    // Priority selection of the fetch address; w_reg_src marks register-sourced targets.
    always_comb begin
        w_pc_sel  = pc_cur + 32'd4;
        w_reg_src = 1'b0;
        if (r_state == EXC) begin
            w_pc_sel = EXC_VEC;
        end else if (eret_en) begin
            w_pc_sel  = epc_in;
            w_reg_src = 1'b1;
        end else if (jr_en) begin
            w_pc_sel  = jr_target;
            w_reg_src = 1'b1;
        end else if (j_en) begin
            w_pc_sel = j_target;
        end else if (br_taken) begin
            w_pc_sel = br_target;
        end
    end

    always_comb begin
        w_stall    = (r_state == RUN) && (hz_stall || (md_busy && md_use));
        w_take_int = (r_state == RUN) && int_req && !hz_stall && !md_busy;
`ifdef PC_ALIGN_CHECK_EN
        w_misalign = (r_state == RUN) && w_reg_src && (w_pc_sel[1:0] != 2'b00) && !w_stall;
`else
        w_misalign = 1'b0;
`endif
        w_state_next = RUN;
        if ((r_state == RUN) && (w_take_int || w_misalign)) begin
            w_state_next = EXC;
        end
    end

    // While reset is held the outputs present the boot address without waiting for a clock.
    always_comb begin
        pc_next = w_pc_sel;
        pc_nen  = w_stall;
        flush   = (r_state == EXC) || (eret_en && !w_stall);
        if (!reset) begin
            pc_next = RESET_PC;
            pc_nen  = 1'b0;
            flush   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A misaligned register target is reported as the faulting address instead of the current PC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_epc <= RESET_PC;
        end else if (w_state_next == EXC) begin
            r_epc <= w_misalign ? w_pc_sel : pc_cur;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (md_start) begin
            r_cnt <= md_is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic r_adel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_adel <= 1'b0;
        end else begin
            r_adel <= w_misalign;
        end
    end

    assign adel = r_adel && (r_state == EXC);
`endif

    assign md_busy = (r_cnt != '0);
    assign epc_out = r_epc;
    assign exc_ack = (r_state == EXC);

endmodule
